// File: rtl/array_stream_arbiter_pkg.sv
// rtl/array_stream_arbiter_pkg.sv - shared primitives for the array stream arbiter
// Purpose: arbitration pointer encoding and rd FIFO sizing shared by the top and its FIFO.
// Ports: none (package).
package array_stream_arbiter_pkg;

  // Side favoured when both a write and a read request are present.
  typedef enum logic {
    PRI_WRITE = 1'b0,
    PRI_READ  = 1'b1
  } pri_t;

  localparam int FIFO_DEPTH = 2;
  // Wide enough to hold 0..FIFO_DEPTH, and occupancy plus one in-flight read.
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 2);

endpackage

// File: rtl/array_stream_arbiter_fifo.sv
// rtl/array_stream_arbiter_fifo.sv - two-entry valid/ready stream FIFO for read data
// Purpose: buffers array read results until the consumer takes them.
// Ports:
//   clk, nrst                      clock, synchronous active-low reset
//   in_data/in_valid/in_ready      push side
//   out_data/out_valid/out_ready   pop side (out_data is the head entry)
//   count                          current occupancy, registered
module stream_fifo2
  import array_stream_arbiter_pkg::*;
#(
  parameter int DN = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [DN-1:0]         in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DN-1:0]         out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [DN-1:0] mem [FIFO_DEPTH];
  // One-bit pointers wrap modulo 2 on their own.
  logic          wr_ptr;
  logic          rd_ptr;
  logic          push;
  logic          pop;

  // in_ready depends only on stored state, never on out_ready.
  assign in_ready  = (count != FIFO_CNT_W'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + FIFO_CNT_W'(1);
      else if (pop && !push) count <= count - FIFO_CNT_W'(1);
    end
  end

  // Storage needs no reset; count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/array_stream_arbiter.sv
// rtl/array_stream_arbiter.sv - arbitrates read and write streams onto a single-port array
// Purpose: grants at most one array command per cycle, alternating priority between
//          writes and reads, and returns read data in order through a 2-entry FIFO.
// Ports:
//   clk, nrst                        clock, synchronous active-low reset
//   ra/ra_valid/ra_ready             read-address stream in
//   rd/rd_valid/rd_ready             read-data stream out
//   wa/wa_valid/wa_ready             write-address stream in
//   wd/wd_valid/wd_ready             write-data stream in (consumed with wa)
//   arr_addr/arr_we/arr_wdata        array command out
//   arr_rdata                        array read data, one cycle after a read command
module array_stream_arbiter
  import array_stream_arbiter_pkg::*;
#(
  parameter int AN = 9,
  parameter int DN = 32
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [AN-1:0] ra,
  input  logic          ra_valid,
  output logic          ra_ready,
  output logic [DN-1:0] rd,
  output logic          rd_valid,
  input  logic          rd_ready,
  input  logic [AN-1:0] wa,
  input  logic          wa_valid,
  output logic          wa_ready,
  input  logic [DN-1:0] wd,
  input  logic          wd_valid,
  output logic          wd_ready,
  output logic [AN-1:0] arr_addr,
  output logic          arr_we,
  output logic [DN-1:0] arr_wdata,
  input  logic [DN-1:0] arr_rdata
);

  pri_t                  pri;
  logic                  in_flight;
  logic [FIFO_CNT_W-1:0] occ;
  logic                  fifo_in_ready;
  logic                  fifo_out_valid;
  logic                  wreq;
  logic                  rreq;
  logic                  wgrant;
  logic                  rgrant;

  // Read credit uses registered occupancy only, so a pop in this cycle is not
  // counted and there is no combinational path from rd_ready to ra_ready.
  always_comb begin
    wreq   = wa_valid && wd_valid;
    rreq   = ra_valid && fifo_in_ready &&
             ((occ + FIFO_CNT_W'(in_flight)) < FIFO_CNT_W'(FIFO_DEPTH));
    wgrant = nrst && wreq && (!rreq || (pri == PRI_WRITE));
    rgrant = nrst && rreq && !wgrant;
  end

  assign wa_ready  = wgrant;
  assign wd_ready  = wgrant;
  assign ra_ready  = rgrant;
  assign arr_we    = wgrant;
  assign arr_addr  = wgrant ? wa : (rgrant ? ra : '0);
  assign arr_wdata = wgrant ? wd : '0;

  // Whichever side was served hands priority to the other; idle cycles hold it.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      pri       <= PRI_WRITE;
      in_flight <= 1'b0;
    end else begin
      in_flight <= rgrant;
      if (wgrant)      pri <= PRI_READ;
      else if (rgrant) pri <= PRI_WRITE;
    end
  end

  stream_fifo2 #(
    .DN(DN)
  ) u_rd_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .in_data   (arr_rdata),
    .in_valid  (in_flight),
    .in_ready  (fifo_in_ready),
    .out_data  (rd),
    .out_valid (fifo_out_valid),
    .out_ready (rd_ready),
    .count     (occ)
  );

  // Mask the head while reset is held so nothing stale is offered.
  assign rd_valid = nrst && fifo_out_valid;

endmodule

// File: tb/tb_array_stream_arbiter.sv
// tb/tb_array_stream_arbiter.sv - self-checking bench for array_stream_arbiter
module tb_array_stream_arbiter;
  localparam int AN = 9;
  localparam int DN = 32;

  logic          clk = 1'b0;
  logic          nrst;
  logic [AN-1:0] ra, wa, arr_addr;
  logic          ra_valid, ra_ready, wa_valid, wa_ready, wd_valid, wd_ready;
  logic [DN-1:0] rd, wd, arr_wdata, arr_rdata;
  logic          rd_valid, rd_ready, arr_we;

  always #5 clk = ~clk;

  array_stream_arbiter #(.AN(AN), .DN(DN)) dut (
    .clk(clk), .nrst(nrst),
    .ra(ra), .ra_valid(ra_valid), .ra_ready(ra_ready),
    .rd(rd), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wa(wa), .wa_valid(wa_valid), .wa_ready(wa_ready),
    .wd(wd), .wd_valid(wd_valid), .wd_ready(wd_ready),
    .arr_addr(arr_addr), .arr_we(arr_we), .arr_wdata(arr_wdata),
    .arr_rdata(arr_rdata)
  );

  // External single-port array: read data one cycle after the command.
  logic [DN-1:0] mem [1<<AN];
  always @(posedge clk) begin
    if (arr_we) mem[arr_addr] <= arr_wdata;
    arr_rdata <= mem[arr_addr];
  end

  // Reference model: outstanding read count, pending results with due cycle,
  // shadow of array contents, and which side is currently favoured.
  typedef struct { logic [DN-1:0] data; int ready; } rd_exp_t;
  rd_exp_t       expq[$];
  logic [DN-1:0] shadow [1<<AN];
  int            cyc = 0;
  int            outstanding = 0;
  bit            favour_read = 1'b0;
  int            errors = 0;
  int            checks = 0;

  function automatic bit m_rreq();
    return (ra_valid === 1'b1) && (outstanding < 2);
  endfunction
  function automatic bit m_wgrant();
    return (nrst === 1'b1) && (wa_valid === 1'b1) && (wd_valid === 1'b1) && (!m_rreq() || !favour_read);
  endfunction
  function automatic bit m_rgrant();
    return (nrst === 1'b1) && m_rreq() && !m_wgrant();
  endfunction
  function automatic bit m_rd_valid();
    return (nrst === 1'b1) && (expq.size() > 0) && (expq[0].ready <= cyc);
  endfunction
  function automatic logic [DN-1:0] m_rd();
    return (expq.size() > 0) ? expq[0].data : '0;
  endfunction

  // Advance one clock and update the model from the inputs of the ending cycle.
  task automatic tick();
    bit wg, rg, pop;
    rd_exp_t e;
    @(posedge clk);
    if (nrst !== 1'b1) begin
      favour_read = 1'b0;
      outstanding = 0;
      expq.delete();
    end else begin
      wg  = m_wgrant();
      rg  = m_rgrant();
      pop = m_rd_valid() && (rd_ready === 1'b1);
      if (pop) begin
        void'(expq.pop_front());
        outstanding--;
      end
      if (wg) begin
        shadow[wa] = wd;
        favour_read = 1'b1;
      end else if (rg) begin
        e.data = shadow[ra];
        e.ready = cyc + 2;
        expq.push_back(e);
        outstanding++;
        favour_read = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    ra_valid = 1'b0;
    wa_valid = 1'b0;
    wd_valid = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; ra_valid = 1'b1; wa_valid = 1'b1; wd_valid = 1'b1; rd_ready = 1'b1;
    ra = 9'd3; wa = 9'd4; wd = 32'h1234;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (ra_ready !== 1'b0) $display("FAIL reset_ra_ready got=%b exp=0", ra_ready);
      if (ra_ready !== 1'b0) errors++;
      checks++; if (wa_ready !== 1'b0) begin errors++; $display("FAIL reset_wa_ready got=%b exp=0", wa_ready); end
      checks++; if (wd_ready !== 1'b0) begin errors++; $display("FAIL reset_wd_ready got=%b exp=0", wd_ready); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
      checks++; if (arr_we !== 1'b0) begin errors++; $display("FAIL reset_arr_we got=%b exp=0", arr_we); end
      checks++; if (arr_addr !== '0) begin errors++; $display("FAIL reset_arr_addr got=%0h exp=0", arr_addr); end
      checks++; if (arr_wdata !== '0) begin errors++; $display("FAIL reset_arr_wdata got=%0h exp=0", arr_wdata); end
      tick();
    end
    nrst = 1'b1;
    idle();
  endtask

  task automatic test_write_read();
    idle(); rd_ready = 1'b1; wa = 9'd5; wd = 32'd77; wa_valid = 1'b1; wd_valid = 1'b1;
    @(negedge clk);
    checks++; if (wa_ready !== 1'b1) begin errors++; $display("FAIL wr_first_grant got=%b exp=1", wa_ready); end
    checks++; if (arr_we !== 1'b1) begin errors++; $display("FAIL wr_arr_we got=%b exp=1", arr_we); end
    checks++; if (arr_addr !== 9'd5) begin errors++; $display("FAIL wr_arr_addr got=%0d exp=5", arr_addr); end
    checks++; if (arr_wdata !== 32'd77) begin errors++; $display("FAIL wr_arr_wdata got=%0d exp=77", arr_wdata); end
    tick();
    idle(); ra = 9'd5; ra_valid = 1'b1;
    @(negedge clk);
    checks++; if (ra_ready !== 1'b1) begin errors++; $display("FAIL rd_accept got=%b exp=1", ra_ready); end
    checks++; if (arr_we !== 1'b0) begin errors++; $display("FAIL rd_arr_we got=%b exp=0", arr_we); end
    checks++; if (arr_addr !== 9'd5) begin errors++; $display("FAIL rd_arr_addr got=%0d exp=5", arr_addr); end
    tick();
    ra_valid = 1'b0;
    @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_lat1_valid got=%b exp=0", rd_valid); end
    tick();
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rd_lat2_valid got=%b exp=1", rd_valid); end
    checks++; if (rd !== 32'd77) begin errors++; $display("FAIL rd_lat2_data got=%0d exp=77", rd); end
    tick();
    @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_after_pop got=%b exp=0", rd_valid); end
  endtask

  task automatic test_stream();
    int issued, got, n, first_acc, first_rx;
    idle(); rd_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wa = AN'(i); wd = DN'(i); wa_valid = 1'b1; wd_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (wa_ready !== 1'b1 || arr_addr !== AN'(i) || arr_wdata !== DN'(i)) begin
        errors++; $display("FAIL preload i=%0d ready=%b addr=%0d data=%0d exp=1/%0d/%0d", i, wa_ready, arr_addr, arr_wdata, i, i);
      end
      tick();
    end
    idle();
    issued = 0; got = 0; n = 0; first_acc = -1; first_rx = -1;
    while (got < 256 && n < 2000) begin
      ra_valid = (issued < 256); ra = issued[AN-1:0];
      @(negedge clk);
      checks++; if (ra_ready !== m_rgrant()) begin errors++; $display("FAIL stream_ra_ready cyc=%0d got=%b exp=%b", cyc, ra_ready, m_rgrant()); end
      checks++; if (rd_valid !== m_rd_valid()) begin errors++; $display("FAIL stream_rd_valid cyc=%0d got=%b exp=%b", cyc, rd_valid, m_rd_valid()); end
      if (rd_valid === 1'b1) begin
        checks++; if (rd !== DN'(got)) begin errors++; $display("FAIL stream_order got=%0d exp=%0d", rd, got); end
        if (first_rx < 0) first_rx = cyc;
        got++;
      end
      if (ra_ready === 1'b1) begin
        if (first_acc < 0) first_acc = cyc;
        issued++;
      end
      tick();
      n++;
    end
    idle();
    checks++; if (got != 256) begin errors++; $display("FAIL stream_count got=%0d exp=256", got); end
    checks++; if (first_rx - first_acc != 2) begin errors++; $display("FAIL stream_latency got=%0d exp=2", first_rx - first_acc); end
  endtask

  task automatic test_alternate();
    nrst = 1'b0; idle(); tick(); nrst = 1'b1;
    rd_ready = 1'b1; ra_valid = 1'b1; wa_valid = 1'b1; wd_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wa = AN'($urandom_range(0, 255)); wd = $urandom; ra = AN'($urandom_range(0, 255));
      @(negedge clk);
      checks++; if (wa_ready !== (k % 2 == 0)) begin errors++; $display("FAIL alt_write k=%0d got=%b exp=%b", k, wa_ready, (k % 2 == 0)); end
      checks++; if (ra_ready !== (k % 2 == 1)) begin errors++; $display("FAIL alt_read k=%0d got=%b exp=%b", k, ra_ready, (k % 2 == 1)); end
      if (m_rd_valid()) begin
        checks++; if (rd_valid !== 1'b1 || rd !== m_rd()) begin errors++; $display("FAIL alt_rd got=%b/%0h exp=1/%0h", rd_valid, rd, m_rd()); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_backpressure();
    int acc, pops;
    idle(); rd_ready = 1'b1; repeat (4) tick();
    rd_ready = 1'b0; ra_valid = 1'b1; ra = AN'($urandom_range(0, 255)); acc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (ra_ready !== m_rgrant()) begin errors++; $display("FAIL bp_ra_ready k=%0d got=%b exp=%b", k, ra_ready, m_rgrant()); end
      if (ra_ready === 1'b1) acc++;
      tick();
    end
    checks++; if (acc != 2) begin errors++; $display("FAIL bp_accepted got=%0d exp=2", acc); end
    wa_valid = 1'b1; wd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wa = AN'($urandom_range(0, 255)); wd = $urandom;
      @(negedge clk);
      checks++; if (wa_ready !== 1'b1) begin errors++; $display("FAIL bp_write_grant k=%0d got=%b exp=1", k, wa_ready); end
      checks++; if (ra_ready !== 1'b0) begin errors++; $display("FAIL bp_ra_blocked k=%0d got=%b exp=0", k, ra_ready); end
      tick();
    end
    wa_valid = 1'b0; wd_valid = 1'b0; rd_ready = 1'b1; acc = 0; pops = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (rd_valid !== m_rd_valid()) begin errors++; $display("FAIL bp_drain_valid k=%0d got=%b exp=%b", k, rd_valid, m_rd_valid()); end
      if (rd_valid === 1'b1) begin
        checks++; if (rd !== m_rd()) begin errors++; $display("FAIL bp_drain_data got=%0h exp=%0h", rd, m_rd()); end
        pops++;
      end
      if (ra_ready === 1'b1) acc++;
      tick();
    end
    idle();
    checks++; if (pops < 2) begin errors++; $display("FAIL bp_drained got=%0d exp>=2", pops); end
    checks++; if (acc < 1) begin errors++; $display("FAIL bp_resumed got=%0d exp>=1", acc); end
  endtask

  task automatic test_write_stall();
    int acc;
    idle(); wa_valid = 1'b1; wd_valid = 1'b0; ra_valid = 1'b1; rd_ready = 1'b1; acc = 0;
    wa = 9'd7; wd = 32'hdead; ra = AN'($urandom_range(0, 255));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (wa_ready !== 1'b0 || wd_ready !== 1'b0 || arr_we !== 1'b0) begin
        errors++; $display("FAIL stall_write k=%0d got=%b%b%b exp=000", k, wa_ready, wd_ready, arr_we);
      end
      checks++; if (ra_ready !== m_rgrant()) begin errors++; $display("FAIL stall_ra_ready k=%0d got=%b exp=%b", k, ra_ready, m_rgrant()); end
      if (rd_valid === 1'b1) begin
        checks++; if (rd !== m_rd()) begin errors++; $display("FAIL stall_rd got=%0h exp=%0h", rd, m_rd()); end
      end
      if (ra_ready === 1'b1) acc++;
      tick();
      if (acc > 0) ra = AN'($urandom_range(0, 255));
    end
    idle();
    checks++; if (acc < 3) begin errors++; $display("FAIL stall_reads got=%0d exp>=3", acc); end
  endtask

  task automatic test_reset_inflight();
    idle(); rd_ready = 1'b1; repeat (4) tick();
    rd_ready = 1'b0; ra = 9'd10; ra_valid = 1'b1;
    @(negedge clk);
    checks++; if (ra_ready !== 1'b1) begin errors++; $display("FAIL rstif_acc0 got=%b exp=1", ra_ready); end
    tick();
    ra = 9'd11;
    @(negedge clk);
    checks++; if (ra_ready !== 1'b1) begin errors++; $display("FAIL rstif_acc1 got=%b exp=1", ra_ready); end
    tick();
    ra_valid = 1'b0;
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rstif_held got=%b exp=1", rd_valid); end
    nrst = 1'b0;
    tick();
    nrst = 1'b1; rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rstif_stale k=%0d got=%b exp=0", k, rd_valid); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      nrst     = ($urandom_range(0, 49) != 0);
      ra_valid = ($urandom_range(0, 1) == 1);
      wa_valid = ($urandom_range(0, 3) != 0);
      wd_valid = ($urandom_range(0, 3) != 0);
      rd_ready = ($urandom_range(0, 2) != 0);
      ra = AN'($urandom_range(0, 255)); wa = AN'($urandom_range(0, 255)); wd = $urandom;
      @(negedge clk);
      checks++; if (wa_ready !== m_wgrant() || wd_ready !== m_wgrant()) begin
        errors++; $display("FAIL rnd_w_ready cyc=%0d got=%b%b exp=%b", cyc, wa_ready, wd_ready, m_wgrant());
      end
      checks++; if (ra_ready !== m_rgrant()) begin errors++; $display("FAIL rnd_ra_ready cyc=%0d got=%b exp=%b", cyc, ra_ready, m_rgrant()); end
      checks++; if (arr_we !== m_wgrant()) begin errors++; $display("FAIL rnd_arr_we cyc=%0d got=%b exp=%b", cyc, arr_we, m_wgrant()); end
      if (m_wgrant() || m_rgrant()) begin
        checks++; if (arr_addr !== (m_wgrant() ? wa : ra)) begin
          errors++; $display("FAIL rnd_arr_addr cyc=%0d got=%0d exp=%0d", cyc, arr_addr, m_wgrant() ? wa : ra);
        end
      end
      if (m_wgrant()) begin
        checks++; if (arr_wdata !== wd) begin errors++; $display("FAIL rnd_arr_wdata cyc=%0d got=%0h exp=%0h", cyc, arr_wdata, wd); end
      end
      checks++; if (rd_valid !== m_rd_valid()) begin errors++; $display("FAIL rnd_rd_valid cyc=%0d got=%b exp=%b", cyc, rd_valid, m_rd_valid()); end
      if (m_rd_valid()) begin
        checks++; if (rd !== m_rd()) begin errors++; $display("FAIL rnd_rd cyc=%0d got=%0h exp=%0h", cyc, rd, m_rd()); end
      end
      tick();
    end
    nrst = 1'b1;
    idle();
  endtask

  initial begin
    idle();
    nrst = 1'b0; rd_ready = 1'b0; ra = '0; wa = '0; wd = '0;
    test_reset();
    test_write_read();
    test_stream();
    test_alternate();
    test_backpressure();
    test_write_stall();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
